// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, header nibble
// and the byte-width constant.
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEND       = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_NIBBLE, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above the
// pointer, wrapping around; one-hot grant plus binary index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);

    int best_s;
    int off_s;

    // Smallest wrapped distance from the pointer wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        best_s  = NUM_REQ;
        off_s   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i >= int'(ptr_i)) begin
                off_s = i - int'(ptr_i);
            end else begin
                off_s = i + NUM_REQ - int'(ptr_i);
            end
            if (req_i[i] && (off_s < best_s)) begin
                best_s     = off_s;
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = ID_W'(i);
                valid_o    = 1'b1;
            end else begin
                best_s = best_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx byte transmitter between NUM_REQ requesters, sending each
// granted word MSB byte first. Define UART_TX_SCHED_HDR_EN to prefix a header byte.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int BYTES_PER_WORD = 8,
    parameter int ID_W           = 1
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [NUM_REQ-1:0]    i_Req,
    input  logic [NUM_REQ*64-1:0] i_Data,
    output logic [NUM_REQ-1:0]    o_Ack,
    output logic                  o_Busy,
    output logic [ID_W-1:0]       o_Grant_Id,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Active,
    input  logic                  i_Tx_Done
);

`ifdef UART_TX_SCHED_HDR_EN
    localparam int HDR_BYTES = 1;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int NBYTES = BYTES_PER_WORD + HDR_BYTES;
    localparam int SR_W   = BYTE_W * NBYTES;
    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int CNT_W  = 4;

    tx_state_e           state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                dv_q, dv_d;
    logic [7:0]          byte_q, byte_d;

    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_W-1:0]     idx_s;
    logic                valid_s;
    logic [63:0]         word_s;
    logic                tx_free_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_i   (i_Req),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .idx_o   (idx_s),
        .valid_o (valid_s)
    );

    // uart_tx has no reset, so a byte is only launched once it is fully idle.
    assign tx_free_s = !i_Tx_Active && !i_Tx_Done;

    // Select the granted requester's word.
    always_comb begin
        word_s = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_s[r]) begin
                word_s = i_Data[64*r +: 64];
            end else begin
                word_s = word_s;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            dv_q    <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            dv_q    <= dv_d;
            byte_q  <= byte_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       state_d = valid_s ? ST_SEND : ST_IDLE;
            ST_SEND:       state_d = tx_free_s ? ST_WAIT_START : ST_SEND;
            ST_WAIT_START: state_d = i_Tx_Active ? ST_WAIT_DONE : ST_WAIT_START;
            ST_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_d = (cnt_q == '0) ? ST_IDLE : ST_SEND;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default:       state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        gid_d  = gid_q;
        busy_d = busy_q;
        ack_d  = '0;
        dv_d   = 1'b0;
        byte_d = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_s) begin
                    ack_d  = grant_s;
                    gid_d  = idx_s;
                    ptr_d  = (idx_s == ID_W'(NUM_REQ - 1)) ? '0 : idx_s + ID_W'(1);
                    busy_d = 1'b1;
                    cnt_d  = CNT_W'(NBYTES);
`ifdef UART_TX_SCHED_HDR_EN
                    sr_d   = {hdr_byte(4'(idx_s)), word_s[WORD_W-1:0]};
`else
                    sr_d   = word_s[WORD_W-1:0];
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (tx_free_s) begin
                    dv_d   = 1'b1;
                    byte_d = sr_q[SR_W-1 -: 8];
                    sr_d   = sr_q << BYTE_W;
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    dv_d = 1'b0;
                end
            end
            ST_WAIT_START: begin
                dv_d = 1'b0;
            end
            ST_WAIT_DONE: begin
                if (i_Tx_Done && (cnt_q == '0)) begin
                    busy_d = 1'b0;
                end else begin
                    busy_d = busy_q;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign o_Ack      = ack_q;
    assign o_Busy     = busy_q;
    assign o_Grant_Id = gid_q;
    assign o_Tx_DV    = dv_q;
    assign o_Tx_Byte  = byte_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural uart_tx model
// (CLKS_PER_BIT=4, Done held for 2 cycles). Honours UART_TX_SCHED_HDR_EN.
module tb_uart_tx_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   req_a, req_b;
    logic [127:0] data_a, data_b;
    logic [1:0]   ack_a, ack_b;
    logic         busy_a, busy_b;
    logic [0:0]   gid_a, gid_b;
    logic         dv_a, dv_b;
    logic [7:0]   byte_a, byte_b;
    logic         act_a, done_a, act_b, done_b;
    int           mcnt_a = 0;
    int           mcnt_b = 0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    uart_tx_sched #(.NUM_REQ(2), .BYTES_PER_WORD(8), .ID_W(1)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req_a), .i_Data(data_a),
        .o_Ack(ack_a), .o_Busy(busy_a), .o_Grant_Id(gid_a),
        .o_Tx_DV(dv_a), .o_Tx_Byte(byte_a),
        .i_Tx_Active(act_a), .i_Tx_Done(done_a)
    );

    uart_tx_sched #(.NUM_REQ(2), .BYTES_PER_WORD(2), .ID_W(1)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req_b), .i_Data(data_b),
        .o_Ack(ack_b), .o_Busy(busy_b), .o_Grant_Id(gid_b),
        .o_Tx_DV(dv_b), .o_Tx_Byte(byte_b),
        .i_Tx_Active(act_b), .i_Tx_Done(done_b)
    );

    // uart_tx model: 10 bits x 4 clocks active, then Done for 2 cycles; no reset.
    always @(posedge clk) mcnt_a <= dv_a ? 42 : ((mcnt_a > 0) ? mcnt_a - 1 : 0);
    always @(posedge clk) mcnt_b <= dv_b ? 42 : ((mcnt_b > 0) ? mcnt_b - 1 : 0);
    assign act_a  = (mcnt_a > 2);
    assign done_a = (mcnt_a == 1) || (mcnt_a == 2);
    assign act_b  = (mcnt_b > 2);
    assign done_b = (mcnt_b == 1) || (mcnt_b == 2);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte capture and launch gate: a DV must never coincide with Active or Done.
    always @(negedge clk) begin
        if (dv_a) begin
            chk("gate_a", {62'd0, act_a, done_a}, 64'd0);
            q_a.push_back(byte_a);
        end
        if (dv_b) begin
            chk("gate_b", {62'd0, act_b, done_b}, 64'd0);
            q_b.push_back(byte_b);
        end
    end

    task automatic check_bytes(input string tag, input int sel, input int id,
                               input logic [63:0] w, input int bpw);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
`ifdef UART_TX_SCHED_HDR_EN
        exp_q.push_back({4'hA, id[3:0]});
`endif
        for (int k = bpw - 1; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
        if (sel == 0) begin
            got_q = q_a;
            q_a.delete();
        end else begin
            got_q = q_b;
            q_b.delete();
        end
        chk({tag, "_nbytes"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk($sformatf("%s_byte%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
    endtask

    task automatic wait_ack_a(output int cyc);
        cyc = 0;
        while (ack_a == 2'b00 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_idle_a();
        int cyc;
        cyc = 0;
        while (busy_a && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_low", 64'(busy_a), 64'd0);
    endtask

    // Serve one word on instance A: ack, grant id, byte stream, busy drop.
    task automatic serve_a(input string tag, input int exp_id, input logic [63:0] w,
                           input bit chk_lat);
        int cyc;
        wait_ack_a(cyc);
        if (chk_lat) chk({tag, "_ack_latency"}, 64'(cyc), 64'd1);
        chk({tag, "_ack"}, 64'(ack_a), 64'd1 << exp_id);
        chk({tag, "_grant_id"}, 64'(gid_a), 64'(exp_id));
        chk({tag, "_busy_set"}, 64'(busy_a), 64'd1);
        req_a[exp_id] = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, 64'(ack_a), 64'd0);
        wait_idle_a();
        check_bytes(tag, 0, exp_id, w, 8);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [63:0] w0;
        logic [63:0] w1;
        int          first;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int id;
        int cyc;
        bit first;

        vecs[0] = '{req: 2'b01, w0: 64'h0123456789ABCDEF, w1: 64'h0,                first: 0};
        vecs[1] = '{req: 2'b10, w0: 64'h0,                w1: 64'hDEADBEEFCAFEF00D, first: 1};
        vecs[2] = '{req: 2'b11, w0: 64'h1122334455667788, w1: 64'h99AABBCCDDEEFF00, first: 0};
        vecs[3] = '{req: 2'b11, w0: 64'hA5A5A5A55A5A5A5A, w1: 64'h0F1E2D3C4B5A6978, first: 0};
        vecs[4] = '{req: 2'b10, w0: 64'h0,                w1: 64'hFF00000000000000, first: 1};
        vecs[5] = '{req: 2'b11, w0: 64'h8000000000000001, w1: 64'h7FFFFFFFFFFFFFFE, first: 0};

        rst = 1'b1;
        req_a = 2'b00; req_b = 2'b00;
        data_a = '0;   data_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_gid", 64'(gid_a), 64'd0);
        chk("rst_dv", 64'(dv_a), 64'd0);
        chk("rst_byte", 64'(byte_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            data_a = {vecs[v].w1, vecs[v].w0};
            req_a  = vecs[v].req;
            id     = vecs[v].first;
            first  = 1'b1;
            while (req_a != 2'b00) begin
                serve_a($sformatf("v%0d_r%0d", v, id), id,
                        (id == 0) ? vecs[v].w0 : vecs[v].w1, first);
                id    = 1 - id;
                first = 1'b0;
            end
        end

        // Reset while uart_tx is busy with the third byte of a requester-1 word.
        data_a = {64'h8877665544332211, 64'h0};
        req_a  = 2'b10;
        wait_ack_a(cyc);
        chk("mid_ack", 64'(ack_a), 64'd2);
        req_a = 2'b00;
        cyc = 0;
        while (!(q_a.size() >= 3 && act_a) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_bytes_before_rst", 64'(q_a.size()), 64'd3);
        chk("mid_active", 64'(act_a), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", 64'(ack_a), 64'd0);
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_gid", 64'(gid_a), 64'd0);
        chk("mid_rst_dv", 64'(dv_a), 64'd0);
        chk("mid_rst_byte", 64'(byte_a), 64'd0);
        rst = 1'b0;
        q_a.delete();
        data_a = {64'hCAFEBABE00C0FFEE, 64'h1357924680ACE0BD};
        req_a  = 2'b11;
        chk("post_rst_tx_busy", 64'(act_a), 64'd1);
        serve_a("post_rst_r0", 0, 64'h1357924680ACE0BD, 1'b1);
        serve_a("post_rst_r1", 1, 64'hCAFEBABE00C0FFEE, 1'b0);

        // Two-byte word configuration.
        data_b = {64'h0, 64'h123456789ABCBEEF};
        req_b  = 2'b01;
        cyc = 0;
        while (ack_b == 2'b00 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("bpw2_ack_latency", 64'(cyc), 64'd1);
        chk("bpw2_ack", 64'(ack_b), 64'd1);
        req_b = 2'b00;
        cyc = 0;
        while (busy_b && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("bpw2_busy_low", 64'(busy_b), 64'd0);
        check_bytes("bpw2", 1, 0, 64'h123456789ABCBEEF, 2);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx byte transmitter between NUM_REQ requesters. Each requester presents a 64-bit word, for example a PUF response or challenge echo.
- The block captures one granted word, serialises it into BYTES_PER_WORD bytes (MSB byte first) and sequences uart_tx through its DV/Active/Done handshake, one byte at a time.
- Sits between the PUF measurement/control logic and the single board UART pin.

Parameters:
- NUM_REQ, 2, number of requesters (1..16).
- BYTES_PER_WORD, 8, bytes sent per word (1..8); the low BYTES_PER_WORD*8 bits of the word are sent.
- ID_W, 1, width of the grant index; must be >= ceil(log2(NUM_REQ)), min 1.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req  in  NUM_REQ  per-requester "word valid"; held until acked.
- i_Data  in  NUM_REQ*64  requester r word at bits [64r+63:64r].
- o_Ack  out  NUM_REQ  one-cycle pulse: word of requester r captured.
- o_Busy  out  1  high from capture until last byte done.
- o_Grant_Id  out  ID_W  index of current/last granted requester.
- o_Tx_DV  out  1  to uart_tx i_Tx_DV; one-cycle pulse.
- o_Tx_Byte  out  8  to uart_tx i_Tx_Byte; valid while o_Tx_DV high.
- i_Tx_Active  in  1  from uart_tx o_Tx_Active.
- i_Tx_Done  in  1  from uart_tx o_Tx_Done; may stay high for 2 cycles.

Behaviour:
- Reset values: o_Ack=0, o_Busy=0, o_Grant_Id=0, o_Tx_DV=0, o_Tx_Byte=0, RR pointer=0, state=IDLE.
- Reset mid-word aborts the word with no ack replay. uart_tx has no reset and finishes its current byte; the SEND gate below guarantees no overlap.
- States: IDLE, SEND, WAIT_START, WAIT_DONE.
- IDLE:
  - If any i_Req is set, grant the first set bit at or after the RR pointer, searching upward with wrap.
  - On grant: capture the word into a shift register, pulse o_Ack[g], set o_Grant_Id=g, RR pointer=(g+1) mod NUM_REQ, o_Busy=1, byte counter=BYTES_PER_WORD, go to SEND.
  - Total latency req→ack: 1 cycle.
- SEND:
  - Wait until i_Tx_Active==0 && i_Tx_Done==0.
  - Then pulse o_Tx_DV for 1 cycle with o_Tx_Byte = current MSB byte (bits [8*BYTES_PER_WORD-1 -: 8]), shift the register left by 8, decrement the counter, go to WAIT_START.
- WAIT_START: wait for i_Tx_Active==1, then go to WAIT_DONE.
- WAIT_DONE:
  - On i_Tx_Done==1: if counter==0, set o_Busy=0 and go to IDLE; else go to SEND.
  - The 2-cycle Done level is absorbed by the SEND gate.
- Simultaneous requests are resolved by RR. A request arriving during busy waits; it is never dropped.
- i_Req deasserted before ack is simply not granted.
- A requester that keeps i_Req high after ack is treated as a new word.
- Words are never interleaved: the grant is held for all bytes.

Optional Feature:
- Macro: UART_TX_SCHED_HDR_EN.
- Defined:
  - Each word is preceded by a header byte {4'hA, grant id zero-extended to 4 bits}, so BYTES_PER_WORD+1 bytes go out per word.
  - The header uses the same SEND/WAIT handshake.
- Undefined: no header; exactly BYTES_PER_WORD bytes per word.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE/SEND/WAIT_START/WAIT_DONE);
  - HDR_NIBBLE=4'hA;
  - byte-width constant 8.
- One natural sub-module: rr_arbiter (NUM_REQ-wide, request vector + pointer in, one-hot grant + index out, combinational). Reusable for other shared PUF resources.

Test Plan:
- Single word:
  - Stimulus: i_Req=2'b01, word 64'h0123456789ABCDEF; uart_tx model with CLKS_PER_BIT=4.
  - Expect: o_Ack[0] pulse 1 cycle after req; 8 DV pulses carrying 01,23,45,67,89,AB,CD,EF in order; o_Busy falls after the 8th Done.
- Contention:
  - Stimulus: both requesters raise i_Req in the same cycle.
  - Expect: grants 0 then 1, then 0 again on the next contention (pointer rotates); no byte interleave.
- Handshake gate:
  - Stimulus: hold i_Tx_Done high for 2 cycles after each byte.
  - Expect: exactly one DV per byte, and no DV while i_Tx_Active=1.
- Reset mid-word:
  - Stimulus: assert i_Reset after 3 bytes, while i_Tx_Active=1.
  - Expect: all outputs go to reset values next cycle. A new req is acked, but its first DV is withheld until uart_tx Active=0 and Done=0.
- Header (UART_TX_SCHED_HDR_EN):
  - Stimulus: requester 1 sends 64'hFF00...00.
  - Expect: bytes A1, FF, 00×7; 9 DV pulses total.
- BYTES_PER_WORD=2:
  - Stimulus: word 64'h...BEEF.
  - Expect: exactly 2 bytes, BE then EF.
